// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO that feeds uart_transmitter one byte at a time.
// Producers can write bursts. The issue FSM waits for the transmitter's
// busy flag to go high and then low again before it sends the next byte.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  tx_busy,
  output logic                  tx_en,
  output logic [DATA_WIDTH-1:0] tx_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wrPtr;
  logic [DEPTH_LOG2-1:0] r_rdPtr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;
  logic                  r_txEn;
  logic [DATA_WIDTH-1:0] r_txData;
  state_t                r_state;

  logic w_full;
  logic w_empty;
  logic w_wrAccept;
  logic w_pop;

  // Status flags come straight from the occupancy counter. A write is accepted
  // only when the FIFO is not full before any pop on the same edge.
  assign w_full     = (r_count == DEPTH_CNT);
  assign w_empty    = (r_count == '0);
  assign w_wrAccept = wr_en && !w_full;
  assign w_pop      = (r_state == IDLE) && !w_empty;

  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign tx_en    = r_txEn;
  assign tx_data  = r_txData;

  // Storage array. It has no reset because stale entries are never read.
  always_ff @(posedge sys_clk) begin
    if (w_wrAccept) begin
      r_mem[r_wrPtr] <= wr_data;
    end
  end

  // Write pointer and overflow flag. A write to a full FIFO gives a one-cycle overflow pulse.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wrPtr    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= wr_en && w_full;
      if (w_wrAccept) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
    end
  end

  // Occupancy counter. If a write and a pop happen on the same edge, they cancel.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_count <= '0;
    end else begin
      case ({w_wrAccept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue FSM. It pops one byte, strobes tx_en for one cycle, then waits for a full busy cycle from the transmitter.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state  <= IDLE;
      r_txEn   <= 1'b0;
      r_txData <= '0;
      r_rdPtr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_txEn <= 1'b0;
          if (!w_empty) begin
            r_txData <= r_mem[r_rdPtr];
            r_rdPtr  <= r_rdPtr + 1'b1;
            r_txEn   <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          r_txEn  <= 1'b0;
          r_state <= ACK;
        end
        ACK: begin
          r_txEn <= 1'b0;
          if (tx_busy) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          r_txEn <= 1'b0;
          if (!tx_busy) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_txEn  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
